// File: rtl/pulse_counter_n.sv
// Terminal-count event counter: counts rising edges of async input c
// after start; flags out in latch or wrap mode.
// Ports: clk, rst_n, start, c, terminal[W], wrap_mode ->
//        count[W], out, busy, overflow (all registered).
module pulse_counter_n #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c,
    input  logic [WIDTH-1:0] terminal,
    input  logic             wrap_mode,
    output logic [WIDTH-1:0] count,
    output logic             out,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   ev;
    logic [WIDTH-1:0]       term_q;
    logic                   mode_q;
    logic [WIDTH-1:0]       nxt;

    // One-cycle pulse per synchronised rising edge of c
    assign ev  = sync[SYNC_STAGES-1] & ~prev;
    assign nxt = count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], c};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            out      <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            term_q   <= '0;
            mode_q   <= 1'b0;
        end else if (start) begin
            // start outranks any coincident event
            state    <= COUNT;
            count    <= '0;
            out      <= 1'b0;
            busy     <= 1'b1;
            overflow <= 1'b0;
            term_q   <= terminal;
            mode_q   <= wrap_mode;
        end else begin
            unique case (state)
                IDLE: begin
                    out  <= 1'b0;
                    busy <= 1'b0;
                end
                COUNT: begin
                    out <= 1'b0;
                    if (ev) begin
                        // terminal 0 matches the all-ones -> 0 rollover
                        if (nxt == term_q) begin
                            out <= 1'b1;
                            if (mode_q) begin
                                count <= '0;
                            end else begin
                                count <= nxt;
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            count <= nxt;
                        end
                    end
                end
                DONE: begin
                    out <= 1'b1;
                    if (ev) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_counter_n.sv
// Bench for pulse_counter_n: WIDTH=4 and WIDTH=2 instances against an
// event-count model, plus directed literal checks.
module tb_pulse_counter_n;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       c;
    logic       wrap_mode;
    logic [3:0] terminal4;
    logic [1:0] terminal2;
    logic [3:0] count4;
    logic [1:0] count2;
    logic       out4, busy4, overflow4;
    logic       out2, busy2, overflow2;

    int vectors;
    int miscompares;
    int out4_hi;

    pulse_counter_n #(.WIDTH(4), .SYNC_STAGES(S)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .c(c),
        .terminal(terminal4), .wrap_mode(wrap_mode),
        .count(count4), .out(out4), .busy(busy4),
        .overflow(overflow4)
    );

    pulse_counter_n #(.WIDTH(2), .SYNC_STAGES(S)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .c(c),
        .terminal(terminal2), .wrap_mode(wrap_mode),
        .count(count2), .out(out2), .busy(busy2),
        .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got,
                         input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Model: an event is a rising edge of c as sampled at clock edges,
    // counted S edges after the first high sample. Per run it tracks
    // events since start against the effective terminal.
    logic [7:0] hist;
    int  wid    [2];
    int  m_nev  [2];
    int  m_teff [2];
    bit  m_run  [2];
    bit  m_done [2];
    bit  m_mode [2];
    bit  m_out  [2];
    bit  m_ovf  [2];

    initial begin
        wid[0] = 4;
        wid[1] = 2;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = '0;
            for (int i = 0; i < 2; i++) begin
                m_nev[i]  = 0;
                m_teff[i] = 0;
                m_run[i]  = 0;
                m_done[i] = 0;
                m_mode[i] = 0;
                m_out[i]  = 0;
                m_ovf[i]  = 0;
            end
        end else begin
            bit ev;
            hist = {hist[6:0], c};
            ev = hist[S] & ~hist[S+1];
            for (int i = 0; i < 2; i++) begin
                int tv;
                tv = (i == 0) ? int'(terminal4) : int'(terminal2);
                if (start) begin
                    m_run[i]  = 1;
                    m_done[i] = 0;
                    m_nev[i]  = 0;
                    m_ovf[i]  = 0;
                    m_out[i]  = 0;
                    m_mode[i] = wrap_mode;
                    m_teff[i] = (tv == 0) ? (1 << wid[i]) : tv;
                end else if (m_run[i] && !m_done[i]) begin
                    if (m_mode[i]) m_out[i] = 0;
                    if (ev) begin
                        m_nev[i]++;
                        if (m_nev[i] == m_teff[i]) begin
                            m_out[i] = 1;
                            if (m_mode[i]) m_nev[i] = 0;
                            else m_done[i] = 1;
                        end
                    end
                end else if (m_done[i] && ev) begin
                    m_ovf[i] = 1;
                end
            end
        end
    end

    function automatic int exp_count(input int i);
        if (m_done[i]) return m_teff[i] % (1 << wid[i]);
        return m_nev[i];
    endfunction

    always @(negedge clk) begin
        check("m4_count", int'(count4), exp_count(0));
        check("m4_out", int'(out4), int'(m_out[0]));
        check("m4_busy", int'(busy4), int'(m_run[0] && !m_done[0]));
        check("m4_ovf", int'(overflow4), int'(m_ovf[0]));
        check("m2_count", int'(count2), exp_count(1));
        check("m2_out", int'(out2), int'(m_out[1]));
        check("m2_busy", int'(busy2), int'(m_run[1] && !m_done[1]));
        check("m2_ovf", int'(overflow2), int'(m_ovf[1]));
        if (out4) out4_hi++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        c = 1'b1;
        repeat (2) step();
        c = 1'b0;
        repeat (2) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int o0;
        rst_n     = 1'b0;
        start     = 1'b0;
        c         = 1'b0;
        wrap_mode = 1'b0;
        terminal4 = 4'd8;
        terminal2 = 2'd1;
        #12;
        check("rst_count4", int'(count4), 0);
        check("rst_busy4", int'(busy4), 0);
        step();
        rst_n = 1'b1;
        step();

        // reset mid-count
        do_start();
        repeat (5) pulse();
        check("mid_count5", int'(count4), 5);
        check("mid_busy", int'(busy4), 1);
        rst_n = 1'b0;
        #1;
        check("arst_count", int'(count4), 0);
        check("arst_out", int'(out4), 0);
        check("arst_busy", int'(busy4), 0);
        check("arst_ovf", int'(overflow4), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) pulse();
        check("nostart_count", int'(count4), 0);
        check("nostart_busy", int'(busy4), 0);

        // WIDTH=2, terminal 0, latch mode
        terminal2 = 2'd0;
        do_start();
        pulse();
        check("w2_c1", int'(count2), 1);
        pulse();
        check("w2_c2", int'(count2), 2);
        pulse();
        check("w2_c3", int'(count2), 3);
        pulse();
        check("w2_c0", int'(count2), 0);
        check("w2_out", int'(out2), 1);
        check("w2_busy", int'(busy2), 0);
        pulse();
        check("w2_ovf", int'(overflow2), 1);
        check("w2_hold", int'(count2), 0);

        // wrap mode, terminal 5, 12 pulses
        terminal4 = 4'd5;
        wrap_mode = 1'b1;
        do_start();
        o0 = out4_hi;
        repeat (12) pulse();
        check("wrap_outcyc", out4_hi - o0, 2);
        check("wrap_count", int'(count4), 2);
        check("wrap_ovf", int'(overflow4), 0);

        // latency
        terminal4 = 4'd8;
        wrap_mode = 1'b0;
        do_start();
        step();
        step();
        c = 1'b1;
        step();
        check("lat_k1", int'(count4), 0);
        step();
        check("lat_k2", int'(count4), 0);
        step();
        check("lat_k3", int'(count4), 1);
        c = 1'b0;
        step();
        step();

        // start coincident with event pulse
        c = 1'b1;
        step();
        step();
        terminal4 = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("coin_count", int'(count4), 0);
        check("coin_busy", int'(busy4), 1);
        c = 1'b0;
        step();
        step();
        terminal4 = 4'd1;
        pulse();
        pulse();
        check("t3_count2", int'(count4), 2);
        check("t3_out0", int'(out4), 0);
        pulse();
        check("t3_count3", int'(count4), 3);
        check("t3_out1", int'(out4), 1);
        check("t3_busy", int'(busy4), 0);

        // overflow then restart from DONE
        pulse();
        check("done_ovf", int'(overflow4), 1);
        check("done_count", int'(count4), 3);
        do_start();
        check("rs_out", int'(out4), 0);
        check("rs_ovf", int'(overflow4), 0);
        check("rs_count", int'(count4), 0);
        check("rs_busy", int'(busy4), 1);

        // start held: events discarded
        start = 1'b1;
        pulse();
        pulse();
        start = 1'b0;
        step();
        check("held_count", int'(count4), 0);
        pulse();
        check("held_after", int'(count4), 1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
